// File: rtl/tb_sim_csr_if.sv
// -----------------------------------------------------------------------------
// tb_sim_csr_if
//
// CSR bus between the test program (master) and the simulation-control
// register block (slave).
//
// Handshake: wr and rd are single-cycle strobes that the slave always
// accepts (there is no ready). A read strobed at clock edge N returns
// rdata together with a one-cycle rd_valid pulse in the cycle after edge N.
// rdata holds its previous value whenever rd_valid is low.
//
// Signals:
//   addr      master->slave  ADDR_W  word address
//   wr        master->slave  1       write strobe
//   wdata     master->slave  32      write data
//   rd        master->slave  1       read strobe
//   rdata     slave->master  32      registered read data
//   rd_valid  slave->master  1       read data valid pulse
// -----------------------------------------------------------------------------
interface tb_sim_csr_if #(
    parameter int unsigned ADDR_W = 4
) ();
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [31:0]       wdata;
    logic              rd;
    logic [31:0]       rdata;
    logic              rd_valid;

    modport master (
        output addr,
        output wr,
        output wdata,
        output rd,
        input  rdata,
        input  rd_valid
    );

    modport slave (
        input  addr,
        input  wr,
        input  wdata,
        input  rd,
        output rdata,
        output rd_valid
    );
endinterface

// File: rtl/tb_sim_csr.sv
// -----------------------------------------------------------------------------
// tb_sim_csr
//
// Memory-mapped simulation-control register block. The test program writes
// stop/finish requests, error events, the partial-test flag and the timeout
// value; the block drives the status/control inputs of the test bench
// control block. Stop/finish requests pass through a drain delay so bus
// activity in flight settles before the simulation is told to end.
//
// Register map (word offsets):
//   0 CTRL    W : bit0 stop, bit1 finish, bit2 partial_test
//               R : {29'b0, partial_test, pend_finish, pend_stop}
//   1 ERROR   RW: write wdata[0]=1 increments a saturating 16-bit count
//   2 TIMEOUT RW: 32-bit timeout value
//   3 COUNT   R : count_vec sampled at the read edge
//   4 STATUS  R : {28'b0, error, draining, do_finish, do_stop}
//   others      : read 0, writes ignored
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   bus           CSR bus (slave modport)
//   count_vec     test bench cycle count
//   error         high while the error count is non-zero
//   do_stop       stop request (registered)
//   do_finish     finish request (registered)
//   partial_test  partial test flag
//   timeout       timeout cycle value
//   dbg_state_o   current FSM state (0 IDLE, 1 DRAIN, 2 DONE)
//
// ERR_CNT_INIT is a test hook: the reset value of the error count, so
// saturation can be reached without tens of thousands of writes. Leave it
// at zero in real use.
// -----------------------------------------------------------------------------
module tb_sim_csr #(
    parameter int unsigned ADDR_W          = 4,
    parameter int unsigned DRAIN_CYCLES    = 8,
    parameter logic [31:0] DEFAULT_TIMEOUT = 32'h0010_0000,
    parameter int unsigned ERR_LIMIT       = 0,
    parameter logic [15:0] ERR_CNT_INIT    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    tb_sim_csr_if.slave bus,
    input  logic [31:0] count_vec,
    output logic        error,
    output logic        do_stop,
    output logic        do_finish,
    output logic        partial_test,
    output logic [31:0] timeout,
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_ERROR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TIMEOUT = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_stop_q, pend_stop_d;
    logic              pend_finish_q, pend_finish_d;
    logic              do_stop_q, do_stop_d;
    logic              do_finish_q, do_finish_d;
    logic              partial_q, partial_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [31:0]       timeout_q, timeout_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rd_valid_q;
    logic [31:0]       rd_mux;

    logic              wr_ctrl;
    logic              wr_err;
    logic              wr_timeout;
    logic              ctrl_stop;
    logic              ctrl_finish;
    logic              err_hit;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign wr_ctrl     = bus.wr && (bus.addr == A_CTRL);
    assign wr_err      = bus.wr && (bus.addr == A_ERROR) && bus.wdata[0];
    assign wr_timeout  = bus.wr && (bus.addr == A_TIMEOUT);
    assign ctrl_stop   = wr_ctrl && bus.wdata[0];
    assign ctrl_finish = wr_ctrl && bus.wdata[1];

    // ------------------------------------------------------------------
    // Plain registers: error count, timeout, partial_test
    // ------------------------------------------------------------------
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (wr_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // The limit is checked against the post-increment count, so the write
    // that reaches the limit is the one that requests finish.
    always_comb begin
        err_hit = 1'b0;
        if (ERR_LIMIT != 0) begin
            err_hit = wr_err && ({16'h0000, err_cnt_d} >= 32'(ERR_LIMIT));
        end
    end

    assign timeout_d = wr_timeout ? bus.wdata : timeout_q;
    assign partial_d = wr_ctrl ? bus.wdata[2] : partial_q;

    // ------------------------------------------------------------------
    // Drain FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_stop_d   = pend_stop_q;
        pend_finish_d = pend_finish_q;

        case (state_q)
            IDLE: begin
                if (ctrl_stop || ctrl_finish || err_hit) begin
                    pend_stop_d   = pend_stop_q | ctrl_stop;
                    pend_finish_d = pend_finish_q | ctrl_finish | err_hit;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                // Late requests join the pending set but never restart the drain.
                pend_stop_d   = pend_stop_q | ctrl_stop;
                pend_finish_d = pend_finish_q | ctrl_finish;
                cnt_d         = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Pending bits are frozen until reset.
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs register off the next state so they rise on the same edge
    // the FSM enters DONE.
    always_comb begin
        do_stop_d   = 1'b0;
        do_finish_d = 1'b0;
        if (state_d == DONE) begin
            do_stop_d   = pend_stop_d;
            do_finish_d = pend_finish_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path: uses pre-write register values
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = 32'h0000_0000;
        case (bus.addr)
            A_CTRL:    rd_mux = {29'b0, partial_q, pend_finish_q, pend_stop_q};
            A_ERROR:   rd_mux = {16'h0000, err_cnt_q};
            A_TIMEOUT: rd_mux = timeout_q;
            A_COUNT:   rd_mux = count_vec;
            A_STATUS:  rd_mux = {28'b0, error, (state_q == DRAIN), do_finish_q, do_stop_q};
            default:   rd_mux = 32'h0000_0000;
        endcase
    end

    assign rdata_d = bus.rd ? rd_mux : rdata_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pend_stop_q   <= 1'b0;
            pend_finish_q <= 1'b0;
            do_stop_q     <= 1'b0;
            do_finish_q   <= 1'b0;
            partial_q     <= 1'b0;
            err_cnt_q     <= ERR_CNT_INIT;
            timeout_q     <= DEFAULT_TIMEOUT;
            rdata_q       <= 32'h0000_0000;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_stop_q   <= pend_stop_d;
            pend_finish_q <= pend_finish_d;
            do_stop_q     <= do_stop_d;
            do_finish_q   <= do_finish_d;
            partial_q     <= partial_d;
            err_cnt_q     <= err_cnt_d;
            timeout_q     <= timeout_d;
            rdata_q       <= rdata_d;
            rd_valid_q    <= bus.rd;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign error        = (err_cnt_q != 16'h0000);
    assign do_stop      = do_stop_q;
    assign do_finish    = do_finish_q;
    assign partial_test = partial_q;
    assign timeout      = timeout_q;
    assign dbg_state_o  = state_q;
    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_tb_sim_csr.sv
// -----------------------------------------------------------------------------
// tb_tb_sim_csr
//
// Three instances of tb_sim_csr:
//   u_m : DRAIN_CYCLES=8, ERR_LIMIT=0  (main register/drain behaviour)
//   u_l : DRAIN_CYCLES=8, ERR_LIMIT=3  (error-limit auto finish)
//   u_s : DRAIN_CYCLES=0, error count starting at 0xFFFE (saturation, no drain)
// Reads push their expected data into a per-instance queue; a monitor per
// instance pops and compares whenever rd_valid is seen.
// -----------------------------------------------------------------------------
module tb_tb_sim_csr;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] count_vec;

    localparam logic [3:0] A_CTRL    = 4'd0;
    localparam logic [3:0] A_ERROR   = 4'd1;
    localparam logic [3:0] A_TIMEOUT = 4'd2;
    localparam logic [3:0] A_COUNT   = 4'd3;
    localparam logic [3:0] A_STATUS  = 4'd4;
    localparam logic [3:0] A_UNMAP   = 4'd6;

    tb_sim_csr_if #(.ADDR_W(4)) bm ();
    tb_sim_csr_if #(.ADDR_W(4)) bl ();
    tb_sim_csr_if #(.ADDR_W(4)) bs ();

    logic        m_error, m_do_stop, m_do_finish, m_partial;
    logic [31:0] m_timeout;
    logic [1:0]  m_state;
    logic        l_error, l_do_stop, l_do_finish, l_partial;
    logic [31:0] l_timeout;
    logic [1:0]  l_state;
    logic        s_error, s_do_stop, s_do_finish, s_partial;
    logic [31:0] s_timeout;
    logic [1:0]  s_state;

    tb_sim_csr #(.ADDR_W(4), .DRAIN_CYCLES(8), .ERR_LIMIT(0)) u_m (
        .clk(clk), .rst_n(rst_n), .bus(bm), .count_vec(count_vec),
        .error(m_error), .do_stop(m_do_stop), .do_finish(m_do_finish),
        .partial_test(m_partial), .timeout(m_timeout), .dbg_state_o(m_state)
    );

    tb_sim_csr #(.ADDR_W(4), .DRAIN_CYCLES(8), .ERR_LIMIT(3)) u_l (
        .clk(clk), .rst_n(rst_n), .bus(bl), .count_vec(count_vec),
        .error(l_error), .do_stop(l_do_stop), .do_finish(l_do_finish),
        .partial_test(l_partial), .timeout(l_timeout), .dbg_state_o(l_state)
    );

    tb_sim_csr #(.ADDR_W(4), .DRAIN_CYCLES(0), .ERR_LIMIT(0), .ERR_CNT_INIT(16'hFFFE)) u_s (
        .clk(clk), .rst_n(rst_n), .bus(bs), .count_vec(count_vec),
        .error(s_error), .do_stop(s_do_stop), .do_finish(s_do_finish),
        .partial_test(s_partial), .timeout(s_timeout), .dbg_state_o(s_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_m[$];
    logic [31:0] exp_l[$];
    logic [31:0] exp_s[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void unexpected(string name, logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: unexpected rd_valid with rdata 0x%08h expected no read data at %0t",
                 name, act, $time);
    endfunction

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bm.rd_valid === 1'b1) begin
            if (exp_m.size() == 0) unexpected("rd_m", bm.rdata);
            else chk("rd_m", bm.rdata, exp_m.pop_front());
        end
    end

    always @(negedge clk) begin
        if (bl.rd_valid === 1'b1) begin
            if (exp_l.size() == 0) unexpected("rd_l", bl.rdata);
            else chk("rd_l", bl.rdata, exp_l.pop_front());
        end
    end

    always @(negedge clk) begin
        if (bs.rd_valid === 1'b1) begin
            if (exp_s.size() == 0) unexpected("rd_s", bs.rdata);
            else chk("rd_s", bs.rdata, exp_s.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(int sel, logic w, logic r, logic [3:0] a, logic [31:0] d);
        case (sel)
            0: begin bm.wr = w; bm.rd = r; bm.addr = a; bm.wdata = d; end
            1: begin bl.wr = w; bl.rd = r; bl.addr = a; bl.wdata = d; end
            default: begin bs.wr = w; bs.rd = r; bs.addr = a; bs.wdata = d; end
        endcase
    endtask

    function automatic logic rd_valid_of(int sel);
        case (sel)
            0: return bm.rd_valid;
            1: return bl.rd_valid;
            default: return bs.rd_valid;
        endcase
    endfunction

    task automatic push(int sel, logic [31:0] exp);
        case (sel)
            0: exp_m.push_back(exp);
            1: exp_l.push_back(exp);
            default: exp_s.push_back(exp);
        endcase
    endtask

    task automatic wr_op(int sel, logic [3:0] a, logic [31:0] d);
        set_bus(sel, 1'b1, 1'b0, a, d);
        tick();
        set_bus(sel, 1'b0, 1'b0, 4'd0, 32'h0);
    endtask

    task automatic rd_op(int sel, logic [3:0] a, logic [31:0] exp);
        push(sel, exp);
        set_bus(sel, 1'b0, 1'b1, a, 32'h0);
        tick();
        set_bus(sel, 1'b0, 1'b0, 4'd0, 32'h0);
        chk1("rd_valid_after_rd", rd_valid_of(sel), 1'b1);
    endtask

    task automatic rw_op(int sel, logic [3:0] a, logic [31:0] d, logic [31:0] exp);
        push(sel, exp);
        set_bus(sel, 1'b1, 1'b1, a, d);
        tick();
        set_bus(sel, 1'b0, 1'b0, 4'd0, 32'h0);
        chk1("rd_valid_after_rw", rd_valid_of(sel), 1'b1);
    endtask

    task automatic report();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic chk_m_reset(string tag);
        chk1({tag, "_error"}, m_error, 1'b0);
        chk1({tag, "_do_stop"}, m_do_stop, 1'b0);
        chk1({tag, "_do_finish"}, m_do_finish, 1'b0);
        chk1({tag, "_partial"}, m_partial, 1'b0);
        chk({tag, "_timeout"}, m_timeout, 32'h0010_0000);
        chk1({tag, "_rd_valid"}, bm.rd_valid, 1'b0);
        chk({tag, "_rdata"}, bm.rdata, 32'h0);
        chk({tag, "_state"}, {30'b0, m_state}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        checks++;
        failures++;
        $display("FAIL watchdog: simulation still running at %0t expected finish earlier", $time);
        report();
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        set_bus(0, 1'b0, 1'b0, 4'd0, 32'h0);
        set_bus(1, 1'b0, 1'b0, 4'd0, 32'h0);
        set_bus(2, 1'b0, 1'b0, 4'd0, 32'h0);
        rst_n     = 1'b0;
        count_vec = 32'h0;
        repeat (3) tick();

        // Reset state
        chk_m_reset("reset");
        chk1("reset_s_error_init", s_error, 1'b1);
        rst_n = 1'b1;

        // Basic reads: TIMEOUT default, STATUS idle, single-cycle pulse
        rd_op(0, A_TIMEOUT, 32'h0010_0000);
        rd_op(0, A_STATUS, 32'h0000_0000);
        tick();
        chk1("rd_valid_pulse_end", bm.rd_valid, 1'b0);
        chk("rdata_hold", bm.rdata, 32'h0000_0000);

        // COUNT sampling and unmapped addresses
        count_vec = 32'hCAFE_0123;
        rd_op(0, A_COUNT, 32'hCAFE_0123);
        wr_op(0, A_UNMAP, 32'hFFFF_FFFF);
        rd_op(0, A_UNMAP, 32'h0000_0000);
        chk1("unmap_no_stop", m_do_stop, 1'b0);

        // Stop at edge N, finish at edge N+3: both assert in cycle N+9
        wr_op(0, A_CTRL, 32'h0000_0005);
        chk1("t3_partial", m_partial, 1'b1);
        chk("t3_state_drain", {30'b0, m_state}, 32'd1);
        tick();
        tick();
        wr_op(0, A_CTRL, 32'h0000_0006);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("t3_stop_wait", m_do_stop, 1'b0);
        end
        tick();
        chk1("t3_do_stop", m_do_stop, 1'b1);
        chk1("t3_do_finish", m_do_finish, 1'b1);
        chk("t3_state_done", {30'b0, m_state}, 32'd2);
        rd_op(0, A_CTRL, 32'h0000_0007);

        // Reset while in DONE
        rst_n = 1'b0;
        tick();
        chk_m_reset("rst_done");
        rst_n = 1'b1;

        // Finish at edge N: draining in N+1..N+8, do_finish from N+9
        wr_op(0, A_CTRL, 32'h0000_0002);
        chk("t2_state_drain", {30'b0, m_state}, 32'd1);
        rd_op(0, A_STATUS, 32'h0000_0004);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk1("t2_finish_wait", m_do_finish, 1'b0);
        end
        tick();
        chk1("t2_do_finish", m_do_finish, 1'b1);
        chk1("t2_do_stop", m_do_stop, 1'b0);
        rd_op(0, A_STATUS, 32'h0000_0002);
        repeat (3) tick();
        chk1("t2_finish_held", m_do_finish, 1'b1);
        wr_op(0, A_CTRL, 32'h0000_0001);
        chk1("t2_done_ignores_stop", m_do_stop, 1'b0);
        wr_op(0, A_CTRL, 32'h0000_0004);
        chk1("t2_done_partial", m_partial, 1'b1);

        // Simultaneous write and read of TIMEOUT returns the old value
        rw_op(0, A_TIMEOUT, 32'd500, 32'h0010_0000);
        chk("to_written", m_timeout, 32'd500);
        rd_op(0, A_TIMEOUT, 32'd500);

        // Error limit 3: third error write at edge M, do_finish in cycle M+9
        wr_op(1, A_ERROR, 32'h0000_0001);
        chk1("t4_error_set", l_error, 1'b1);
        chk("t4_idle_1", {30'b0, l_state}, 32'd0);
        wr_op(1, A_ERROR, 32'h0000_0001);
        chk("t4_idle_2", {30'b0, l_state}, 32'd0);
        wr_op(1, A_ERROR, 32'h0000_0001);
        chk("t4_drain", {30'b0, l_state}, 32'd1);
        wr_op(1, A_ERROR, 32'h0000_0000);
        rd_op(1, A_ERROR, 32'h0000_0003);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("t4_finish_wait", l_do_finish, 1'b0);
        end
        tick();
        chk1("t4_do_finish", l_do_finish, 1'b1);
        chk1("t4_do_stop", l_do_stop, 1'b0);

        // Saturation from 0xFFFE, then zero-drain stop
        rd_op(2, A_ERROR, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            wr_op(2, A_ERROR, 32'h0000_0001);
        end
        rd_op(2, A_ERROR, 32'h0000_FFFF);
        chk1("t5_error", s_error, 1'b1);
        chk("t5_state_idle", {30'b0, s_state}, 32'd0);
        wr_op(2, A_CTRL, 32'h0000_0001);
        chk1("t5_do_stop_next_cycle", s_do_stop, 1'b1);
        chk1("t5_do_finish", s_do_finish, 1'b0);
        chk("t5_state_done", {30'b0, s_state}, 32'd2);

        // Drain and confirm every read was answered
        repeat (3) tick();
        chk("queue_m_empty", 32'(exp_m.size()), 32'd0);
        chk("queue_l_empty", 32'(exp_l.size()), 32'd0);
        chk("queue_s_empty", 32'(exp_s.size()), 32'd0);

        report();
        $finish;
    end

endmodule
